// File: rtl/issue_queue_age_if.sv
`default_nettype none
// ============================================================================
//  Module   : issue_queue_age_if
//  Brief    : Dispatch, wakeup, issue and flush signal bundle for issue_queue_age.
//  Revision : 1.0 - initial release
// ============================================================================
interface issue_queue_age_if #(
    parameter int DEPTH      = 8,
    parameter int PREG_W     = 7,
    parameter int ROB_W      = 3,
    parameter int NUM_WAKEUP = 2,
    parameter int NUM_FU     = 8,
    parameter int PAYLOAD_W  = 128
) ();
    localparam int FU_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // dispatch side
    logic                         disp_valid;
    logic                         disp_ready;
    logic [PAYLOAD_W-1:0]         disp_payload;
    logic [PREG_W-1:0]            disp_rs1;
    logic [PREG_W-1:0]            disp_rs2;
    logic                         disp_rs1_rdy;
    logic                         disp_rs2_rdy;
    logic [FU_W-1:0]              disp_fu_sel;
    logic [ROB_W-1:0]             disp_rob_idx;

    // wakeup broadcast and FU availability
    logic [NUM_WAKEUP-1:0]        wk_valid;
    logic [NUM_WAKEUP*PREG_W-1:0] wk_tag;
    logic [NUM_FU-1:0]            fu_ready;

    // issue side
    logic                         iss_valid;
    logic                         iss_ready;
    logic [PAYLOAD_W-1:0]         iss_payload;
    logic [PREG_W-1:0]            iss_rs1;
    logic [PREG_W-1:0]            iss_rs2;
    logic [FU_W-1:0]              iss_fu_sel;
    logic [ROB_W-1:0]             iss_rob_idx;

    // flush and occupancy
    logic                         flush;
    logic [(2**ROB_W)-1:0]        flush_mask;
    logic [CNT_W-1:0]             count;

    modport master (
        output disp_valid, disp_payload, disp_rs1, disp_rs2, disp_rs1_rdy,
               disp_rs2_rdy, disp_fu_sel, disp_rob_idx, wk_valid, wk_tag,
               fu_ready, iss_ready, flush, flush_mask,
        input  disp_ready, iss_valid, iss_payload, iss_rs1, iss_rs2,
               iss_fu_sel, iss_rob_idx, count
    );

    modport slave (
        input  disp_valid, disp_payload, disp_rs1, disp_rs2, disp_rs1_rdy,
               disp_rs2_rdy, disp_fu_sel, disp_rob_idx, wk_valid, wk_tag,
               fu_ready, iss_ready, flush, flush_mask,
        output disp_ready, iss_valid, iss_payload, iss_rs1, iss_rs2,
               iss_fu_sel, iss_rob_idx, count
    );
endinterface
`default_nettype wire

// File: rtl/issue_queue_age.sv
`default_nettype none
// ============================================================================
//  Module   : issue_queue_age
//  Brief    : Age-matrix ordered issue queue with operand wakeup and ROB-mask flush.
//  Revision : 1.0 - initial release
// ============================================================================
module issue_queue_age #(
    parameter int DEPTH      = 8,
    parameter int PREG_W     = 7,
    parameter int ROB_W      = 3,
    parameter int NUM_WAKEUP = 2,
    parameter int NUM_FU     = 8,
    parameter int PAYLOAD_W  = 128
) (
    input  wire logic        clk,
    input  wire logic        rst,
    issue_queue_age_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam int FU_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    // entry state
    logic [DEPTH-1:0]     r_valid;
    logic [DEPTH-1:0]     r_rdy1;
    logic [DEPTH-1:0]     r_rdy2;
    logic [PREG_W-1:0]    r_rs1     [DEPTH];
    logic [PREG_W-1:0]    r_rs2     [DEPTH];
    logic [FU_W-1:0]      r_fu      [DEPTH];
    logic [ROB_W-1:0]     r_rob     [DEPTH];
    logic [PAYLOAD_W-1:0] r_payload [DEPTH];
    logic [DEPTH-1:0]     r_age     [DEPTH];   // r_age[i][j]: i older than j
    logic [CNT_W-1:0]     r_count;

    logic [DEPTH-1:0]     w_rdy1;
    logic [DEPTH-1:0]     w_rdy2;
    logic [DEPTH-1:0]     w_req;
    logic [DEPTH-1:0]     w_grant;
    logic [DEPTH-1:0]     w_kill;
    logic [DEPTH-1:0]     w_col     [DEPTH];
    logic [IDX_W-1:0]     w_gnt_idx;
    logic [IDX_W-1:0]     w_free_idx;
    logic [CNT_W-1:0]     w_kill_cnt;
    logic [CNT_W-1:0]     w_count_nxt;
    logic [DEPTH-1:0]     w_valid_nxt;
    logic [DEPTH-1:0]     w_rdy1_nxt;
    logic [DEPTH-1:0]     w_rdy2_nxt;
    logic                 w_disp_ready;
    logic                 w_disp;
    logic                 w_iss_valid;
    logic                 w_issue;
    logic                 w_disp_rdy1;
    logic                 w_disp_rdy2;

    // Tag 0 is the hardwired-zero register and never matches a broadcast.
    function automatic logic f_wake(
        input logic [PREG_W-1:0]            tag,
        input logic [NUM_WAKEUP-1:0]        wk_v,
        input logic [NUM_WAKEUP*PREG_W-1:0] wk_t
    );
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < NUM_WAKEUP; k++) begin
            if (wk_v[k] && (wk_t[k*PREG_W +: PREG_W] == tag)) begin
                hit = 1'b1;
            end
        end
        return hit && (tag != '0);
    endfunction

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_entry
            assign w_rdy1[i] = r_rdy1[i] | (r_rs1[i] == '0)
                             | f_wake(r_rs1[i], bus.wk_valid, bus.wk_tag);
            assign w_rdy2[i] = r_rdy2[i] | (r_rs2[i] == '0)
                             | f_wake(r_rs2[i], bus.wk_valid, bus.wk_tag);
            assign w_req[i]  = r_valid[i] & w_rdy1[i] & w_rdy2[i]
                             & bus.fu_ready[r_fu[i]] & ~bus.flush;
            assign w_kill[i] = bus.flush & r_valid[i] & bus.flush_mask[r_rob[i]];

            for (genvar j = 0; j < DEPTH; j++) begin : g_col
                assign w_col[i][j] = r_age[j][i];
            end

            // Win only when no other requester is older than this entry.
            assign w_grant[i] = w_req[i] & ~(|(w_req & w_col[i]));
        end
    endgenerate

    // Grant is one-hot by construction, so an OR-encode suffices.
    always_comb begin
        w_gnt_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_grant[i]) begin
                w_gnt_idx = w_gnt_idx | IDX_W'(i);
            end
        end
    end

    always_comb begin
        w_free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_free_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        w_kill_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_kill_cnt = w_kill_cnt + CNT_W'(w_kill[i]);
        end
    end

    assign w_disp_ready = (r_count < CNT_W'(DEPTH)) & ~bus.flush;
    assign w_disp       = bus.disp_valid & w_disp_ready;
    assign w_iss_valid  = |w_req;
    assign w_issue      = w_iss_valid & bus.iss_ready;

    assign w_disp_rdy1 = bus.disp_rs1_rdy | (bus.disp_rs1 == '0)
                       | f_wake(bus.disp_rs1, bus.wk_valid, bus.wk_tag);
    assign w_disp_rdy2 = bus.disp_rs2_rdy | (bus.disp_rs2 == '0)
                       | f_wake(bus.disp_rs2, bus.wk_valid, bus.wk_tag);

    // Flush gates both w_req and w_disp_ready, so issue and dispatch are zero then.
    assign w_count_nxt = r_count + CNT_W'(w_disp) - CNT_W'(w_issue) - w_kill_cnt;

    always_comb begin
        w_valid_nxt = r_valid & ~w_kill;
        w_rdy1_nxt  = w_rdy1;
        w_rdy2_nxt  = w_rdy2;
        if (w_issue) begin
            w_valid_nxt[w_gnt_idx] = 1'b0;
        end
        if (w_disp) begin
            w_valid_nxt[w_free_idx] = 1'b1;
            w_rdy1_nxt[w_free_idx]  = w_disp_rdy1;
            w_rdy2_nxt[w_free_idx]  = w_disp_rdy2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_rdy1  <= '0;
            r_rdy2  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_age[i] <= '0;
            end
        end else begin
            r_valid <= w_valid_nxt;
            r_rdy1  <= w_rdy1_nxt;
            r_rdy2  <= w_rdy2_nxt;
            r_count <= w_count_nxt;
            if (w_disp) begin
                // New entry is younger than everything resident.
                r_age[w_free_idx] <= '0;
                for (int j = 0; j < DEPTH; j++) begin
                    r_age[j][w_free_idx] <= r_valid[j];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_disp) begin
            r_rs1[w_free_idx]     <= bus.disp_rs1;
            r_rs2[w_free_idx]     <= bus.disp_rs2;
            r_fu[w_free_idx]      <= bus.disp_fu_sel;
            r_rob[w_free_idx]     <= bus.disp_rob_idx;
            r_payload[w_free_idx] <= bus.disp_payload;
        end
    end

    assign bus.disp_ready  = w_disp_ready;
    assign bus.iss_valid   = w_iss_valid;
    assign bus.iss_payload = r_payload[w_gnt_idx];
    assign bus.iss_rs1     = r_rs1[w_gnt_idx];
    assign bus.iss_rs2     = r_rs2[w_gnt_idx];
    assign bus.iss_fu_sel  = r_fu[w_gnt_idx];
    assign bus.iss_rob_idx = r_rob[w_gnt_idx];
    assign bus.count       = r_count;

endmodule
`default_nettype wire

// File: tb/tb_issue_queue_age.sv
`default_nettype none
// ============================================================================
//  Module   : tb_issue_queue_age
//  Brief    : Directed vector table plus random traffic against a sequence-number model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_issue_queue_age;
    localparam int DEPTH      = 8;
    localparam int PREG_W     = 7;
    localparam int ROB_W      = 3;
    localparam int NUM_WAKEUP = 2;
    localparam int NUM_FU     = 8;
    localparam int PAYLOAD_W  = 128;
    localparam int FU_W       = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    issue_queue_age_if #(
        .DEPTH(DEPTH), .PREG_W(PREG_W), .ROB_W(ROB_W),
        .NUM_WAKEUP(NUM_WAKEUP), .NUM_FU(NUM_FU), .PAYLOAD_W(PAYLOAD_W)
    ) bus ();

    issue_queue_age #(
        .DEPTH(DEPTH), .PREG_W(PREG_W), .ROB_W(ROB_W),
        .NUM_WAKEUP(NUM_WAKEUP), .NUM_FU(NUM_FU), .PAYLOAD_W(PAYLOAD_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: age is the dispatch sequence number, smaller is older.
    typedef struct {
        bit                   v;
        bit                   r1;
        bit                   r2;
        logic [PREG_W-1:0]    s1;
        logic [PREG_W-1:0]    s2;
        logic [FU_W-1:0]      fu;
        logic [ROB_W-1:0]     rob;
        logic [PAYLOAD_W-1:0] pl;
        int unsigned          seq;
    } ment_t;

    ment_t       m [DEPTH];
    int unsigned m_seq = 0;
    bit          e_rdy1 [DEPTH];
    bit          e_rdy2 [DEPTH];
    int          e_best;
    bit          e_drdy;

    function automatic bit m_wake(input logic [PREG_W-1:0] tag);
        if (tag == 0) return 1'b0;
        for (int k = 0; k < NUM_WAKEUP; k++) begin
            if (bus.wk_valid[k] && bus.wk_tag[k*PREG_W +: PREG_W] == tag) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m[i].v = 1'b0;
    endtask

    // Move to the falling edge, predict outputs from the model and compare.
    task automatic sample();
        int cnt;
        #4;
        e_best = -1;
        cnt    = 0;
        for (int i = 0; i < DEPTH; i++) begin
            e_rdy1[i] = m[i].r1 || (m[i].s1 == 0) || m_wake(m[i].s1);
            e_rdy2[i] = m[i].r2 || (m[i].s2 == 0) || m_wake(m[i].s2);
            if (m[i].v) begin
                cnt++;
                if (e_rdy1[i] && e_rdy2[i] && bus.fu_ready[m[i].fu] && !bus.flush) begin
                    if (e_best < 0 || m[i].seq < m[e_best].seq) e_best = i;
                end
            end
        end
        e_drdy = (cnt < DEPTH) && !bus.flush;
        check("mdl_iss_valid", bus.iss_valid, e_best >= 0);
        check("mdl_disp_ready", bus.disp_ready, e_drdy);
        check("mdl_count", bus.count, cnt);
        if (e_best >= 0) begin
            check("mdl_iss_rob", bus.iss_rob_idx, m[e_best].rob);
            check("mdl_iss_rs1", bus.iss_rs1, m[e_best].s1);
            check("mdl_iss_rs2", bus.iss_rs2, m[e_best].s2);
            check("mdl_iss_fu", bus.iss_fu_sel, m[e_best].fu);
            check("mdl_iss_payload", bus.iss_payload, m[e_best].pl);
        end
    endtask

    // Cross the rising edge and apply the same transition to the model.
    task automatic advance();
        int slot;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            slot = -1;
            for (int i = DEPTH - 1; i >= 0; i--) if (!m[i].v) slot = i;
            for (int i = 0; i < DEPTH; i++) begin
                if (m[i].v) begin
                    m[i].r1 = e_rdy1[i];
                    m[i].r2 = e_rdy2[i];
                end
            end
            if (bus.flush) begin
                for (int i = 0; i < DEPTH; i++)
                    if (m[i].v && bus.flush_mask[m[i].rob]) m[i].v = 1'b0;
            end else begin
                if (e_best >= 0 && bus.iss_ready) m[e_best].v = 1'b0;
                if (bus.disp_valid && e_drdy && slot >= 0) begin
                    m[slot].v   = 1'b1;
                    m[slot].r1  = bus.disp_rs1_rdy || (bus.disp_rs1 == 0) || m_wake(bus.disp_rs1);
                    m[slot].r2  = bus.disp_rs2_rdy || (bus.disp_rs2 == 0) || m_wake(bus.disp_rs2);
                    m[slot].s1  = bus.disp_rs1;
                    m[slot].s2  = bus.disp_rs2;
                    m[slot].fu  = bus.disp_fu_sel;
                    m[slot].rob = bus.disp_rob_idx;
                    m[slot].pl  = bus.disp_payload;
                    m[slot].seq = m_seq;
                    m_seq++;
                end
            end
        end
        #1;
    endtask

    task automatic drive(input bit dv, input logic [6:0] rs1, input bit r1,
                         input logic [6:0] rs2, input bit r2, input logic [2:0] fu,
                         input logic [2:0] rob, input logic [1:0] wkv,
                         input logic [6:0] wt0, input logic [6:0] wt1,
                         input logic [7:0] fur, input bit irdy, input bit fl,
                         input logic [7:0] mask);
        bus.disp_valid   = dv;
        bus.disp_rs1     = rs1;
        bus.disp_rs1_rdy = r1;
        bus.disp_rs2     = rs2;
        bus.disp_rs2_rdy = r2;
        bus.disp_fu_sel  = fu;
        bus.disp_rob_idx = rob;
        bus.disp_payload = {$urandom, $urandom, $urandom, $urandom};
        bus.wk_valid     = wkv;
        bus.wk_tag       = {wt1, wt0};
        bus.fu_ready     = fur;
        bus.iss_ready    = irdy;
        bus.flush        = fl;
        bus.flush_mask   = mask;
    endtask

    typedef struct {
        bit         dv;
        logic [6:0] rs1;
        bit         r1;
        logic [6:0] rs2;
        bit         r2;
        logic [2:0] fu;
        logic [2:0] rob;
        logic [1:0] wkv;
        logic [6:0] wt;
        logic [7:0] fur;
        bit         irdy;
        bit         fl;
        logic [7:0] mask;
        bit         e_iv;
        logic [2:0] e_rob;
        logic [3:0] e_cnt;
        bit         e_drdy;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t V(bit dv, logic [6:0] rs1, bit r1, logic [6:0] rs2, bit r2,
                               logic [2:0] fu, logic [2:0] rob, logic [1:0] wkv,
                               logic [6:0] wt, logic [7:0] fur, bit irdy, bit fl,
                               logic [7:0] mask, bit e_iv, logic [2:0] e_rob,
                               logic [3:0] e_cnt, bit e_drdy);
        vec_t t;
        t.dv = dv; t.rs1 = rs1; t.r1 = r1; t.rs2 = rs2; t.r2 = r2; t.fu = fu;
        t.rob = rob; t.wkv = wkv; t.wt = wt; t.fur = fur; t.irdy = irdy;
        t.fl = fl; t.mask = mask; t.e_iv = e_iv; t.e_rob = e_rob;
        t.e_cnt = e_cnt; t.e_drdy = e_drdy;
        return t;
    endfunction

    initial begin
        // Expected values are what the outputs show in that cycle, before its edge.
        // Age order: A,B,C; A leaves; D lands in slot 0 but is youngest.
        tbl.push_back(V(1, 10, 0, 0, 0, 1, 0, 2'b00,  0, 8'hFF, 1, 0, 8'h00, 0, 0, 0, 1));
        tbl.push_back(V(1, 20, 0, 0, 0, 1, 1, 2'b00,  0, 8'hFF, 1, 0, 8'h00, 0, 0, 1, 1));
        tbl.push_back(V(1, 20, 0, 0, 0, 1, 2, 2'b00,  0, 8'hFF, 1, 0, 8'h00, 0, 0, 2, 1));
        tbl.push_back(V(0,  0, 0, 0, 0, 0, 0, 2'b01, 10, 8'hFF, 1, 0, 8'h00, 1, 0, 3, 1));
        tbl.push_back(V(1, 20, 0, 0, 0, 1, 3, 2'b00,  0, 8'hFF, 1, 0, 8'h00, 0, 0, 2, 1));
        tbl.push_back(V(0,  0, 0, 0, 0, 0, 0, 2'b01, 20, 8'hFF, 1, 0, 8'h00, 1, 1, 3, 1));
        tbl.push_back(V(0,  0, 0, 0, 0, 0, 0, 2'b00,  0, 8'hFF, 1, 0, 8'h00, 1, 2, 2, 1));
        tbl.push_back(V(0,  0, 0, 0, 0, 0, 0, 2'b00,  0, 8'hFF, 1, 0, 8'h00, 1, 3, 1, 1));
        // Same-cycle wakeup on port 1 only.
        tbl.push_back(V(1,  5, 0, 0, 0, 2, 4, 2'b00,  0, 8'hFF, 1, 0, 8'h00, 0, 0, 0, 1));
        tbl.push_back(V(0,  0, 0, 0, 0, 0, 0, 2'b10,  5, 8'hFF, 1, 0, 8'h00, 1, 4, 1, 1));
        // Fill with FUs blocked, then backpressure, then drain.
        for (int k = 0; k < 8; k++)
            tbl.push_back(V(1, 0, 1, 0, 1, 3'(k), 3'(k), 2'b00, 0, 8'h00, 1, 0, 8'h00, 0, 0, 4'(k), 1));
        for (int k = 0; k < 3; k++)
            tbl.push_back(V(1, 0, 1, 0, 1, 0, 7, 2'b00, 0, 8'hFF, 0, 0, 8'h00, 1, 0, 8, 0));
        tbl.push_back(V(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 8'hFF, 1, 0, 8'h00, 1, 0, 8, 0));
        for (int k = 1; k < 8; k++)
            tbl.push_back(V(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 8'hFF, 1, 0, 8'h00, 1, 3'(k), 4'(8 - k), 1));
        // Selective flush of rob 4..6; survivors capture the wakeup seen during flush.
        for (int k = 1; k < 7; k++)
            tbl.push_back(V(1, 30, 0, 0, 0, 0, 3'(k), 2'b00, 0, 8'hFF, 1, 0, 8'h00, 0, 0, 4'(k - 1), 1));
        tbl.push_back(V(1,  0, 1, 0, 1, 0, 7, 2'b01, 30, 8'hFF, 1, 1, 8'h70, 0, 0, 6, 0));
        tbl.push_back(V(0,  0, 0, 0, 0, 0, 0, 2'b00,  0, 8'hFF, 1, 0, 8'h00, 1, 1, 3, 1));
        tbl.push_back(V(0,  0, 0, 0, 0, 0, 0, 2'b00,  0, 8'hFF, 1, 0, 8'h00, 1, 2, 2, 1));
        tbl.push_back(V(0,  0, 0, 0, 0, 0, 0, 2'b00,  0, 8'hFF, 1, 0, 8'h00, 1, 3, 1, 1));
        // Tag 0 is ready; FU 3 blocked lets younger FU 2 entry go first.
        tbl.push_back(V(1,  0, 0, 0, 0, 3, 4, 2'b00,  0, 8'hF7, 1, 0, 8'h00, 0, 0, 0, 1));
        tbl.push_back(V(0,  0, 0, 0, 0, 0, 0, 2'b00,  0, 8'hF7, 1, 0, 8'h00, 0, 0, 1, 1));
        tbl.push_back(V(1,  0, 1, 0, 1, 2, 5, 2'b00,  0, 8'hF7, 1, 0, 8'h00, 0, 0, 1, 1));
        tbl.push_back(V(0,  0, 0, 0, 0, 0, 0, 2'b00,  0, 8'hF7, 1, 0, 8'h00, 1, 5, 2, 1));
        tbl.push_back(V(0,  0, 0, 0, 0, 0, 0, 2'b00,  0, 8'hFF, 1, 0, 8'h00, 1, 4, 1, 1));
        // Dispatch colliding with a wakeup of its own source tag.
        tbl.push_back(V(1,  0, 0, 9, 0, 1, 6, 2'b01,  9, 8'hFF, 1, 0, 8'h00, 0, 0, 0, 1));
        tbl.push_back(V(0,  0, 0, 0, 0, 0, 0, 2'b00,  0, 8'hFF, 1, 0, 8'h00, 1, 6, 1, 1));
        tbl.push_back(V(0,  0, 0, 0, 0, 0, 0, 2'b00,  0, 8'hFF, 1, 0, 8'h00, 0, 0, 0, 1));

        drive(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 8'hFF, 1, 0, 8'h00);
        model_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        sample();
        check("reset_count", bus.count, 0);
        check("reset_disp_ready", bus.disp_ready, 1);
        check("reset_iss_valid", bus.iss_valid, 0);
        advance();

        foreach (tbl[r]) begin
            drive(tbl[r].dv, tbl[r].rs1, tbl[r].r1, tbl[r].rs2, tbl[r].r2, tbl[r].fu,
                  tbl[r].rob, tbl[r].wkv, tbl[r].wt, tbl[r].wt, tbl[r].fur,
                  tbl[r].irdy, tbl[r].fl, tbl[r].mask);
            sample();
            check($sformatf("row%0d_iv", r), bus.iss_valid, tbl[r].e_iv);
            check($sformatf("row%0d_count", r), bus.count, tbl[r].e_cnt);
            check($sformatf("row%0d_drdy", r), bus.disp_ready, tbl[r].e_drdy);
            if (tbl[r].e_iv) check($sformatf("row%0d_rob", r), bus.iss_rob_idx, tbl[r].e_rob);
            advance();
        end

        // Reset in the middle of traffic wipes the queue regardless of inputs.
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 1, 0, 1, 3'(k), 3'(k), 2'b00, 0, 0, 8'h00, 1, 0, 8'h00);
            sample();
            advance();
        end
        rst = 1'b1;
        drive(1, 0, 1, 0, 1, 1, 5, 2'b00, 0, 0, 8'hFF, 1, 0, 8'h00);
        sample();
        check("midrst_count_before", bus.count, 3);
        advance();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 8'hFF, 1, 0, 8'h00);
        sample();
        check("midrst_count", bus.count, 0);
        check("midrst_iss_valid", bus.iss_valid, 0);
        check("midrst_disp_ready", bus.disp_ready, 1);
        advance();

        // Random traffic with a small tag space so wakeups hit often.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 399) == 0);
            drive($urandom_range(0, 99) < 60,
                  7'($urandom_range(0, 7)), $urandom_range(0, 3) == 0,
                  7'($urandom_range(0, 7)), $urandom_range(0, 3) == 0,
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  2'($urandom_range(0, 3)),
                  7'($urandom_range(0, 7)), 7'($urandom_range(0, 7)),
                  8'($urandom_range(0, 255) | $urandom_range(0, 255)),
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 99) < 4,
                  8'($urandom_range(0, 255)));
            sample();
            advance();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
